// File: rtl/apb_master.sv
// APB requester: runs one SETUP/ACCESS transfer per local command
// and returns a single-cycle response with read data or a timeout flag.
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TO_LAST_I);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 timeout_hit;

  // Held low while in reset so nothing is offered as accepted.
  assign cmd_ready   = (state == IDLE) && PRESET;
  // Last allowed wait cycle: a PREADY=0 edge here aborts the transfer.
  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  // Transfer sequencer with all bus and response outputs registered.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: one default instance against a
// wait-state slave model, one TIMEOUT=4 instance against a stuck slave.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       sel = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic       m_cmd_valid, m_cmd_ready, m_rsp_valid, m_rsp_err;
  logic [7:0] m_rsp_rdata, m_paddr, m_pwdata, m_prdata;
  logic       m_psel, m_penable, m_pwrite, m_pready;

  logic       t_cmd_valid, t_cmd_ready, t_rsp_valid, t_rsp_err;
  logic [7:0] t_rsp_rdata, t_paddr, t_pwdata, t_prdata;
  logic       t_psel, t_penable, t_pwrite, t_pready;

  always #5 PCLK = ~PCLK;

  assign m_cmd_valid = cmd_valid & ~sel;
  assign t_cmd_valid = cmd_valid & sel;

  apb_master u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(m_cmd_valid), .cmd_ready(m_cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(m_rsp_valid), .rsp_rdata(m_rsp_rdata), .rsp_err(m_rsp_err),
    .PSEL(m_psel), .PENABLE(m_penable), .PWRITE(m_pwrite),
    .PADDR(m_paddr), .PWDATA(m_pwdata),
    .PRDATA(m_prdata), .PREADY(m_pready)
  );

  apb_master #(.TIMEOUT(4)) u_dut_to (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
    .PSEL(t_psel), .PENABLE(t_penable), .PWRITE(t_pwrite),
    .PADDR(t_paddr), .PWDATA(t_pwdata),
    .PRDATA(t_prdata), .PREADY(t_pready)
  );

  // Slave model for the default instance: PREADY after m_wait_n
  // stalled ACCESS edges (1 = registered-ready team slave).
  logic [7:0] mem [0:255];
  int         m_acc = 0;
  int         m_wait_n = 1;
  logic       m_fixed = 1'b0;
  logic [7:0] m_fixed_val = 8'h00;

  assign m_pready = m_psel && m_penable && (m_acc >= m_wait_n);
  assign m_prdata = m_fixed ? m_fixed_val : mem[m_paddr];

  always @(posedge PCLK) begin
    if (m_psel && m_penable && !m_pready) m_acc <= m_acc + 1;
    else m_acc <= 0;
    if (m_psel && m_penable && m_pready && m_pwrite)
      mem[m_paddr] <= m_pwdata;
  end

  // Slave model for the timeout instance.
  int t_acc = 0;
  int t_wait_n = 255;

  assign t_pready = t_psel && t_penable && (t_acc >= t_wait_n);
  assign t_prdata = 8'hEE;

  always @(posedge PCLK) begin
    if (t_psel && t_penable && !t_pready) t_acc <= t_acc + 1;
    else t_acc <= 0;
  end

  // Observed signals of the instance selected by sel.
  logic       s_cmd_ready, s_rsp_valid, s_rsp_err;
  logic       s_psel, s_penable, s_pwrite;
  logic [7:0] s_rsp_rdata, s_paddr, s_pwdata;

  assign s_cmd_ready = sel ? t_cmd_ready : m_cmd_ready;
  assign s_rsp_valid = sel ? t_rsp_valid : m_rsp_valid;
  assign s_rsp_err   = sel ? t_rsp_err   : m_rsp_err;
  assign s_rsp_rdata = sel ? t_rsp_rdata : m_rsp_rdata;
  assign s_psel      = sel ? t_psel      : m_psel;
  assign s_penable   = sel ? t_penable   : m_penable;
  assign s_pwrite    = sel ? t_pwrite    : m_pwrite;
  assign s_paddr     = sel ? t_paddr     : m_paddr;
  assign s_pwdata    = sel ? t_pwdata    : m_pwdata;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Issue one command; report the cycle of rsp_valid (0 if never seen).
  task automatic run_cmd(
    input  logic       w,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output int         rcyc,
    output logic [7:0] rd,
    output logic       er,
    output logic       setup_ok,
    output logic       stable,
    output logic       idle_after
  );
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    setup_ok   = s_psel && !s_penable;
    stable     = 1'b1;
    rcyc       = 0;
    rd         = 8'hxx;
    er         = 1'bx;
    idle_after = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (s_rsp_valid) begin
        rcyc       = c;
        rd         = s_rsp_rdata;
        er         = s_rsp_err;
        idle_after = !s_psel && !s_penable && s_cmd_ready;
        break;
      end
      if (s_psel && (s_paddr !== a || s_pwrite !== w || s_pwdata !== d))
        stable = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    PRESET    = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (m_psel !== 1'b0) begin
        n_err++; $display("FAIL reset_psel got %b want 0", m_psel);
      end
      n_vec++;
      if (m_penable !== 1'b0) begin
        n_err++; $display("FAIL reset_penable got %b want 0", m_penable);
      end
      n_vec++;
      if (m_rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_rsp_valid got %b want 0", m_rsp_valid);
      end
      n_vec++;
      if (m_cmd_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_cmd_ready got %b want 0", m_cmd_ready);
      end
    end
    n_vec++;
    if (m_paddr !== 8'h00 || m_pwdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_bus got %h/%h want 00/00", m_paddr, m_pwdata);
    end
    n_vec++;
    if (m_rsp_rdata !== 8'h00 || m_rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rsp got %h/%b want 00/0", m_rsp_rdata, m_rsp_err);
    end
    cmd_valid = 1'b0;
    PRESET    = 1'b1;
    #1;
    n_vec++;
    if (m_cmd_ready !== 1'b1 || t_cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_cmd_ready got %b/%b want 1/1",
               m_cmd_ready, t_cmd_ready);
    end
  endtask

  task automatic test_write_read();
    int         rc;
    logic [7:0] rd;
    logic       er, su, st, id;
    sel = 1'b0; m_wait_n = 1; m_fixed = 1'b0;
    run_cmd(1'b1, 8'h03, 8'h5A, rc, rd, er, su, st, id);
    n_vec++;
    if (rc !== 4) begin
      n_err++; $display("FAIL wr_latency got %0d want 4", rc);
    end
    n_vec++;
    if (rd !== 8'h00 || er !== 1'b0) begin
      n_err++; $display("FAIL wr_rsp got %h/%b want 00/0", rd, er);
    end
    n_vec++;
    if (su !== 1'b1 || st !== 1'b1 || id !== 1'b1) begin
      n_err++;
      $display("FAIL wr_bus setup/stable/idle got %b%b%b want 111", su, st, id);
    end
    tick();
    n_vec++;
    if (s_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL wr_pulse got %b want 0", s_rsp_valid);
    end
    run_cmd(1'b0, 8'h03, 8'h77, rc, rd, er, su, st, id);
    n_vec++;
    if (rc !== 4) begin
      n_err++; $display("FAIL rd_latency got %0d want 4", rc);
    end
    n_vec++;
    if (rd !== 8'h5A || er !== 1'b0) begin
      n_err++; $display("FAIL rd_rsp got %h/%b want 5a/0", rd, er);
    end
    n_vec++;
    if (su !== 1'b1 || st !== 1'b1 || id !== 1'b1) begin
      n_err++;
      $display("FAIL rd_bus setup/stable/idle got %b%b%b want 111", su, st, id);
    end
    tick();
  endtask

  task automatic test_wait_states();
    int         rc;
    logic [7:0] rd;
    logic       er, su, st, id;
    sel = 1'b0; m_wait_n = 5; m_fixed = 1'b1; m_fixed_val = 8'hC3;
    run_cmd(1'b0, 8'h10, 8'h00, rc, rd, er, su, st, id);
    n_vec++;
    if (rc !== 8) begin
      n_err++; $display("FAIL ws_latency got %0d want 8", rc);
    end
    n_vec++;
    if (rd !== 8'hC3 || er !== 1'b0) begin
      n_err++; $display("FAIL ws_rsp got %h/%b want c3/0", rd, er);
    end
    n_vec++;
    if (st !== 1'b1) begin
      n_err++; $display("FAIL ws_stable got %b want 1", st);
    end
    tick();
    n_vec++;
    if (s_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL ws_pulse got %b want 0", s_rsp_valid);
    end
    m_wait_n = 1; m_fixed = 1'b0;
  endtask

  task automatic test_timeout();
    int         rc;
    logic [7:0] rd;
    logic       er, su, st, id;
    sel = 1'b1; t_wait_n = 255;
    run_cmd(1'b0, 8'h20, 8'h00, rc, rd, er, su, st, id);
    n_vec++;
    if (rc !== 6) begin
      n_err++; $display("FAIL to_latency got %0d want 6", rc);
    end
    n_vec++;
    if (rd !== 8'h00 || er !== 1'b1) begin
      n_err++; $display("FAIL to_rsp got %h/%b want 00/1", rd, er);
    end
    n_vec++;
    if (id !== 1'b1) begin
      n_err++; $display("FAIL to_idle got %b want 1", id);
    end
    tick();
    n_vec++;
    if (s_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL to_pulse got %b want 0", s_rsp_valid);
    end
    t_wait_n = 3;
    run_cmd(1'b0, 8'h21, 8'h00, rc, rd, er, su, st, id);
    n_vec++;
    if (rc !== 6 || rd !== 8'hEE || er !== 1'b0) begin
      n_err++;
      $display("FAIL to_race got %0d/%h/%b want 6/ee/0", rc, rd, er);
    end
    tick();
    t_wait_n = 4;
    run_cmd(1'b1, 8'h22, 8'h99, rc, rd, er, su, st, id);
    n_vec++;
    if (rc !== 6 || rd !== 8'h00 || er !== 1'b1) begin
      n_err++;
      $display("FAIL to_late got %0d/%h/%b want 6/00/1", rc, rd, er);
    end
    tick();
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic       qw [3];
    logic [7:0] qa [3];
    logic [7:0] qd [3];
    int         acc_e [3];
    int         rsp_e [3];
    int         ni, nr;
    logic [7:0] last;
    logic       acc;
    qw[0] = 1'b1; qa[0] = 8'h01; qd[0] = 8'h11;
    qw[1] = 1'b1; qa[1] = 8'h02; qd[1] = 8'h22;
    qw[2] = 1'b0; qa[2] = 8'h01; qd[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      acc_e[i] = -1; rsp_e[i] = -1;
    end
    ni = 0; nr = 0; last = 8'hxx;
    sel = 1'b0; m_wait_n = 1; m_fixed = 1'b0;
    cmd_write = qw[0]; cmd_addr = qa[0]; cmd_wdata = qd[0];
    cmd_valid = 1'b1;
    for (int e = 0; e < 40 && nr < 3; e++) begin
      acc = cmd_valid && s_cmd_ready;
      tick();
      if (acc) begin
        acc_e[ni] = e;
        ni++;
        if (ni < 3) begin
          cmd_write = qw[ni]; cmd_addr = qa[ni]; cmd_wdata = qd[ni];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (s_rsp_valid) begin
        rsp_e[nr] = e;
        last = s_rsp_rdata;
        nr++;
      end
    end
    cmd_valid = 1'b0;
    n_vec++;
    if (nr !== 3 || ni !== 3) begin
      n_err++; $display("FAIL b2b_count got %0d/%0d want 3/3", ni, nr);
    end
    n_vec++;
    if (rsp_e[0] !== 3 || acc_e[1] !== 4) begin
      n_err++;
      $display("FAIL b2b_handoff got rsp %0d acc %0d want 3/4",
               rsp_e[0], acc_e[1]);
    end
    n_vec++;
    if (acc_e[2] !== 8 || rsp_e[2] !== 11) begin
      n_err++;
      $display("FAIL b2b_third got acc %0d rsp %0d want 8/11",
               acc_e[2], rsp_e[2]);
    end
    n_vec++;
    if (last !== 8'h11) begin
      n_err++; $display("FAIL b2b_rdata got %h want 11", last);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int         rc;
    logic [7:0] rd;
    logic       er, su, st, id, saw;
    sel = 1'b0; m_wait_n = 8; m_fixed = 1'b0;
    cmd_write = 1'b0; cmd_addr = 8'h03; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    n_vec++;
    if (s_psel !== 1'b1 || s_penable !== 1'b1) begin
      n_err++;
      $display("FAIL mid_access got %b%b want 11", s_psel, s_penable);
    end
    PRESET = 1'b0;
    tick();
    n_vec++;
    if (s_psel !== 1'b0 || s_penable !== 1'b0 || s_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got %b%b%b want 000",
               s_psel, s_penable, s_rsp_valid);
    end
    PRESET = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      tick();
      if (s_rsp_valid || s_psel) saw = 1'b1;
    end
    n_vec++;
    if (saw !== 1'b0) begin
      n_err++; $display("FAIL mid_quiet got %b want 0", saw);
    end
    m_wait_n = 1;
    run_cmd(1'b0, 8'h03, 8'h00, rc, rd, er, su, st, id);
    n_vec++;
    if (rc !== 4 || rd !== 8'h5A || er !== 1'b0) begin
      n_err++;
      $display("FAIL mid_next got %0d/%h/%b want 4/5a/0", rc, rd, er);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
